// File: rtl/sync_fifo_pkg.sv
// Shared helpers for the FIFO family: pointer/count width derivation and
// wrap-aware pointer increment for arbitrary (non power-of-two) depths.
package sync_fifo_pkg;

  // Address width for a DEPTH-entry array; a 1-entry array still needs one bit.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Occupancy must represent 0..DEPTH inclusive.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int unsigned next_ptr(input int unsigned ptr,
                                           input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

  typedef struct packed {
    logic overflow;
    logic underflow;
  } fifo_err_t;

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH storage: one synchronous write port, one asynchronous read
// port. Contents are intentionally not reset.
module fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int PTR_W = 4
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [PTR_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_prog.sv
// Parametrised single-clock FIFO with occupancy count, programmable almost
// thresholds, optional first-word-fall-through and sticky error flags.
module sync_fifo_prog
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int FWFT  = 0,
  localparam int CNT_W = cnt_w(DEPTH),
  localparam int PTR_W = ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             res,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rdata,
  output logic             rvalid,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  input  logic [CNT_W-1:0] af_level,
  input  logic [CNT_W-1:0] ae_level,
  output logic [CNT_W-1:0] count,
  output logic             overflow,
  output logic             underflow,
  input  logic             err_clr
);

  // Handshake: a write is taken when wr_en is high and there is room, where
  // a read accepted in the same cycle counts as room; a read is taken when
  // rd_en is high and the FIFO is non-empty. Rejected requests are dropped
  // and recorded in the sticky overflow/underflow flags.

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [WIDTH-1:0] mem_rdata;
  logic             rd_accept;
  logic             wr_accept;
  fifo_err_t        err_set;

  assign full         = (count == CNT_W'(DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (count >= af_level);
  assign almost_empty = (count <= ae_level);

  assign rd_accept = rd_en & ~empty;
  assign wr_accept = wr_en & (~full | rd_accept);

  assign err_set.overflow  = wr_en & full & ~rd_accept;
  assign err_set.underflow = rd_en & empty;

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk   (clk),
    .wr_en (wr_accept),
    .waddr (wr_ptr),
    .wdata (wdata),
    .raddr (rd_ptr),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_accept) begin
        wr_ptr <= PTR_W'(next_ptr(32'(wr_ptr), DEPTH));
      end
      if (rd_accept) begin
        rd_ptr <= PTR_W'(next_ptr(32'(rd_ptr), DEPTH));
      end
      case ({wr_accept, rd_accept})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // A fresh error wins over a coincident clear so no event is ever lost.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= err_set.overflow  | (overflow  & ~err_clr);
      underflow <= err_set.underflow | (underflow & ~err_clr);
    end
  end

  if (FWFT != 0) begin : g_fwft
    assign rdata  = mem_rdata;
    assign rvalid = ~empty;
  end else begin : g_std
    logic [WIDTH-1:0] rdata_q;
    logic             rvalid_q;

    always_ff @(posedge clk or negedge res) begin
      if (!res) begin
        rdata_q  <= '0;
        rvalid_q <= 1'b0;
      end else begin
        rvalid_q <= rd_accept;
        if (rd_accept) begin
          rdata_q <= mem_rdata;
        end
      end
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
  end

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Bench for sync_fifo_prog: three instances (16-deep standard, 10-deep
// standard, 16-deep FWFT) driven in phases against a queue-based model.
module tb_sync_fifo_prog;

  logic       clk = 1'b0;
  logic       res;
  logic       wr_en, rd_en, err_clr;
  logic [7:0] wdata;
  logic [4:0] af_level, ae_level;

  logic [7:0] a_rdata, b_rdata, c_rdata;
  logic       a_rvalid, b_rvalid, c_rvalid;
  logic       a_full, b_full, c_full;
  logic       a_empty, b_empty, c_empty;
  logic       a_af, b_af, c_af;
  logic       a_ae, b_ae, c_ae;
  logic [4:0] a_count, c_count;
  logic [3:0] b_count;
  logic       a_ovf, b_ovf, c_ovf;
  logic       a_udf, b_udf, c_udf;

  logic [7:0] obs_rdata;
  logic       obs_rvalid, obs_full, obs_empty, obs_af, obs_ae, obs_ovf, obs_udf;
  logic [4:0] obs_count;

  int total = 0;
  int bad   = 0;
  int sel;

  logic [7:0] exp_q[$];
  int         depth;
  bit         fwft;
  bit         m_ovf, m_udf, m_rvalid;
  logic [7:0] m_rdata;

  always #5 clk = ~clk;

  sync_fifo_prog #(.WIDTH(8), .DEPTH(16), .FWFT(0)) u_a (
    .clk(clk), .res(res), .wr_en(wr_en), .wdata(wdata), .rd_en(rd_en),
    .rdata(a_rdata), .rvalid(a_rvalid), .full(a_full), .empty(a_empty),
    .almost_full(a_af), .almost_empty(a_ae), .af_level(af_level),
    .ae_level(ae_level), .count(a_count), .overflow(a_ovf),
    .underflow(a_udf), .err_clr(err_clr));

  sync_fifo_prog #(.WIDTH(8), .DEPTH(10), .FWFT(0)) u_b (
    .clk(clk), .res(res), .wr_en(wr_en), .wdata(wdata), .rd_en(rd_en),
    .rdata(b_rdata), .rvalid(b_rvalid), .full(b_full), .empty(b_empty),
    .almost_full(b_af), .almost_empty(b_ae), .af_level(af_level[3:0]),
    .ae_level(ae_level[3:0]), .count(b_count), .overflow(b_ovf),
    .underflow(b_udf), .err_clr(err_clr));

  sync_fifo_prog #(.WIDTH(8), .DEPTH(16), .FWFT(1)) u_c (
    .clk(clk), .res(res), .wr_en(wr_en), .wdata(wdata), .rd_en(rd_en),
    .rdata(c_rdata), .rvalid(c_rvalid), .full(c_full), .empty(c_empty),
    .almost_full(c_af), .almost_empty(c_ae), .af_level(af_level),
    .ae_level(ae_level), .count(c_count), .overflow(c_ovf),
    .underflow(c_udf), .err_clr(err_clr));

  always_comb begin
    case (sel)
      0: begin
        obs_rdata = a_rdata; obs_rvalid = a_rvalid; obs_full = a_full;
        obs_empty = a_empty; obs_af = a_af; obs_ae = a_ae;
        obs_count = a_count; obs_ovf = a_ovf; obs_udf = a_udf;
      end
      1: begin
        obs_rdata = b_rdata; obs_rvalid = b_rvalid; obs_full = b_full;
        obs_empty = b_empty; obs_af = b_af; obs_ae = b_ae;
        obs_count = {1'b0, b_count}; obs_ovf = b_ovf; obs_udf = b_udf;
      end
      default: begin
        obs_rdata = c_rdata; obs_rvalid = c_rvalid; obs_full = c_full;
        obs_empty = c_empty; obs_af = c_af; obs_ae = c_ae;
        obs_count = c_count; obs_ovf = c_ovf; obs_udf = c_udf;
      end
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_ovf    = 1'b0;
    m_udf    = 1'b0;
    m_rvalid = 1'b0;
    m_rdata  = 8'h00;
  endtask

  // Behaviour of one clock edge given the occupancy just before it.
  task automatic model_edge(input bit we, input bit re, input logic [7:0] wd,
                            input bit clr);
    int  n;
    bit  rd_ok, wr_ok, new_ovf, new_udf;
    logic [7:0] head;
    n       = exp_q.size();
    rd_ok   = re && (n > 0);
    wr_ok   = we && ((n < depth) || rd_ok);
    new_ovf = we && (n == depth) && !rd_ok;
    new_udf = re && (n == 0);
    m_rvalid = 1'b0;
    if (rd_ok) begin
      head = exp_q.pop_front();
      if (!fwft) begin
        m_rdata  = head;
        m_rvalid = 1'b1;
      end
    end
    if (wr_ok) exp_q.push_back(wd);
    m_ovf = new_ovf || (m_ovf && !clr);
    m_udf = new_udf || (m_udf && !clr);
  endtask

  task automatic check_all(input string ph);
    int n;
    n = exp_q.size();
    check({ph, ".count"},     32'(obs_count), 32'(n));
    check({ph, ".full"},      32'(obs_full),  32'(n == depth));
    check({ph, ".empty"},     32'(obs_empty), 32'(n == 0));
    check({ph, ".almost_f"},  32'(obs_af),    32'(n >= int'(af_level)));
    check({ph, ".almost_e"},  32'(obs_ae),    32'(n <= int'(ae_level)));
    check({ph, ".overflow"},  32'(obs_ovf),   32'(m_ovf));
    check({ph, ".underflow"}, 32'(obs_udf),   32'(m_udf));
    if (!fwft) begin
      check({ph, ".rvalid"}, 32'(obs_rvalid), 32'(m_rvalid));
      check({ph, ".rdata"},  32'(obs_rdata),  32'(m_rdata));
    end else begin
      check({ph, ".rvalid"}, 32'(obs_rvalid), 32'(n > 0));
      if (n > 0) check({ph, ".rdata"}, 32'(obs_rdata), 32'(exp_q[0]));
    end
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic cycle(input string ph, input bit we, input bit re,
                       input logic [7:0] wd, input bit clr);
    wr_en   = we;
    rd_en   = re;
    wdata   = wd;
    err_clr = clr;
    @(posedge clk);
    model_edge(we, re, wd, clr);
    #1;
    check_all(ph);
    @(negedge clk);
  endtask

  task automatic do_reset(input string ph);
    wr_en = 0; rd_en = 0; wdata = 0; err_clr = 0;
    res = 1'b0;
    model_reset();
    @(negedge clk);
    check_all(ph);
    @(negedge clk);
    res = 1'b1;
  endtask

  task automatic random_run(input string ph, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      cycle(ph, $urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50,
            8'($urandom_range(0, 255)), $urandom_range(0, 15) == 0);
    end
  endtask

  initial begin
    res = 1'b1; wr_en = 0; rd_en = 0; wdata = 0; err_clr = 0;
    af_level = 5'd0; ae_level = 5'd3;
    @(negedge clk);

    // 16-deep standard: reset with af_level 0, fill, overflow, full r+w, drain.
    sel = 0; depth = 16; fwft = 0;
    do_reset("a_rst");
    af_level = 5'd12;
    for (int i = 1; i <= 16; i++) cycle("a_fill", 1, 0, 8'(i), 0);
    cycle("a_ovf", 1, 0, 8'hAA, 0);
    cycle("a_idle", 0, 0, 8'h00, 0);
    cycle("a_fullrw", 1, 1, 8'h55, 0);
    for (int i = 0; i < 16; i++) cycle("a_drain", 0, 1, 8'h00, 0);
    cycle("a_udf", 0, 1, 8'h00, 0);
    cycle("a_hold", 0, 0, 8'h00, 0);
    cycle("a_clr", 0, 0, 8'h00, 1);
    cycle("a_clr_udf", 0, 1, 8'h00, 1);
    cycle("a_empty_rw", 1, 1, 8'h77, 0);
    random_run("a_rand", 300);

    // 10-deep standard: interleaved index stream exercises wrap.
    sel = 1; depth = 10; fwft = 0;
    do_reset("b_rst");
    for (int i = 0; i < 25; i++) cycle("b_ilv", 1, i >= 3, 8'(i), 0);
    for (int i = 0; i < 4; i++) cycle("b_tail", 0, 1, 8'h00, 0);
    for (int i = 0; i < 12; i++) cycle("b_fill", 1, 0, 8'(8'h80 + i), 0);
    random_run("b_rand", 300);

    // 16-deep FWFT, then asynchronous reset in the middle of a burst.
    sel = 2; depth = 16; fwft = 1;
    do_reset("c_rst");
    cycle("c_3c", 1, 0, 8'h3C, 0);
    cycle("c_hold", 0, 0, 8'h00, 0);
    random_run("c_rand", 200);
    for (int i = 0; i < 5; i++) cycle("c_burst", 1, 0, 8'(8'hC0 + i), 0);
    #2;
    res = 1'b0;
    model_reset();
    #1;
    check_all("c_async");
    @(negedge clk);
    res = 1'b1;
    cycle("c_fresh", 1, 0, 8'h5A, 0);
    cycle("c_pop", 0, 1, 8'h00, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
